// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the word-addressed PC, drives imem, fills IF/ID.
// Optional MIPS branch-delay-slot behaviour is enabled with `define DELAY_SLOT_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              req_en_q, req_en_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0]   if_id_pc_plus_q, if_id_pc_plus_d;
  logic [XLEN-1:0]   if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic              req_c;
  logic              accept_c;
  logic [XLEN-1:0]   pc_inc_c;
  logic [XLEN-1:0]   hold_inc_c;
`ifdef DELAY_SLOT_EN
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
`endif

  // Request is suppressed in HOLD and in the first cycle out of reset.
  assign req_c      = (state_q == S_FETCH) && req_en_q;
  assign accept_c   = req_c && imem_ready;
  assign pc_inc_c   = pc_q + XLEN'(1);
  assign hold_inc_c = hold_pc_q + XLEN'(1);

  assign imem_addr     = pc_q;
  assign imem_req      = req_c;
  assign if_id_pc      = if_id_pc_q;
  assign if_id_pc_plus = if_id_pc_plus_q;
  assign if_id_instr   = if_id_instr_q;
  assign if_id_valid   = if_id_valid_q;

  // Next-state and IF/ID update logic.
  always_comb begin
    state_d         = state_q;
    req_en_d        = 1'b1;
    pc_d            = pc_q;
    hold_pc_d       = hold_pc_q;
    hold_instr_d    = hold_instr_q;
    if_id_pc_d      = if_id_pc_q;
    if_id_pc_plus_d = if_id_pc_plus_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_valid_d   = if_id_valid_q;
`ifdef DELAY_SLOT_EN
    pend_d          = pend_q;
    pend_tgt_d      = pend_tgt_q;

    if (state_q == S_HOLD) begin
      // The held instruction is the slot; the next fetch can go straight to the target.
      if (redirect_i && !pend_q) pc_d = redirect_target;
      if (!stall_i) begin
        if_id_pc_d      = hold_pc_q;
        if_id_pc_plus_d = hold_inc_c;
        if_id_instr_d   = hold_instr_q;
        if_id_valid_d   = 1'b1;
        state_d         = S_FETCH;
      end
    end else if (accept_c) begin
      if (pend_q)          pc_d = pend_tgt_q;
      else if (redirect_i) pc_d = redirect_target;
      else                 pc_d = pc_inc_c;
      pend_d = 1'b0;
      if (!stall_i) begin
        if_id_pc_d      = pc_q;
        if_id_pc_plus_d = pc_inc_c;
        if_id_instr_d   = imem_rdata;
        if_id_valid_d   = 1'b1;
      end else begin
        hold_pc_d    = pc_q;
        hold_instr_d = imem_rdata;
        state_d      = S_HOLD;
      end
    end else begin
      if (req_c && !stall_i) if_id_valid_d = 1'b0;
      if (redirect_i && !pend_q) begin
        pend_d     = 1'b1;
        pend_tgt_d = redirect_target;
      end
    end
`else
    if (redirect_i) begin
      pc_d          = redirect_target;
      if_id_valid_d = 1'b0;
      state_d       = S_FETCH;
    end else if (state_q == S_HOLD) begin
      if (!stall_i) begin
        if_id_pc_d      = hold_pc_q;
        if_id_pc_plus_d = hold_inc_c;
        if_id_instr_d   = hold_instr_q;
        if_id_valid_d   = 1'b1;
        state_d         = S_FETCH;
      end
    end else if (accept_c) begin
      pc_d = pc_inc_c;
      if (!stall_i) begin
        if_id_pc_d      = pc_q;
        if_id_pc_plus_d = pc_inc_c;
        if_id_instr_d   = imem_rdata;
        if_id_valid_d   = 1'b1;
      end else begin
        hold_pc_d    = pc_q;
        hold_instr_d = imem_rdata;
        state_d      = S_HOLD;
      end
    end else if (req_c && !stall_i) begin
      if_id_valid_d = 1'b0;
    end
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      req_en_q        <= 1'b0;
      pc_q            <= RESET_PC;
      hold_pc_q       <= '0;
      hold_instr_q    <= '0;
      if_id_pc_q      <= '0;
      if_id_pc_plus_q <= '0;
      if_id_instr_q   <= '0;
      if_id_valid_q   <= 1'b0;
`ifdef DELAY_SLOT_EN
      pend_q          <= 1'b0;
      pend_tgt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      req_en_q        <= req_en_d;
      pc_q            <= pc_d;
      hold_pc_q       <= hold_pc_d;
      hold_instr_q    <= hold_instr_d;
      if_id_pc_q      <= if_id_pc_d;
      if_id_pc_plus_q <= if_id_pc_plus_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_valid_q   <= if_id_valid_d;
`ifdef DELAY_SLOT_EN
      pend_q          <= pend_d;
      pend_tgt_q      <= pend_tgt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed steps then random traffic against a behavioural model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the fetch front end.
  logic [31:0] m_pc, m_hpc, m_hinstr, m_vpc, m_vplus, m_vinstr, m_ptgt;
  bit          m_hold, m_valid, m_started, m_pend;

  fetch_pc_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_target(redirect_target),
    .if_id_pc(if_id_pc), .if_id_pc_plus(if_id_pc_plus),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr",     imem_addr,          m_pc);
    chk("imem_req",      32'(imem_req),      32'(m_started && !m_hold));
    chk("if_id_valid",   32'(if_id_valid),   32'(m_valid));
    chk("if_id_pc",      if_id_pc,           m_vpc);
    chk("if_id_pc_plus", if_id_pc_plus,      m_vplus);
    chk("if_id_instr",   if_id_instr,        m_vinstr);
  endtask

  task automatic deliver(input logic [31:0] p, input logic [31:0] ins);
    m_vpc = p; m_vplus = p + 32'd1; m_vinstr = ins; m_valid = 1'b1;
  endtask

  task automatic model(input bit r, input bit rdy, input bit st, input bit rd, input logic [31:0] tgt);
    bit          req;
    logic [31:0] nxt;
    if (!r) begin
      m_pc = 32'h100; m_hold = 0; m_hpc = 0; m_hinstr = 0;
      m_vpc = 0; m_vplus = 0; m_vinstr = 0; m_valid = 0;
      m_started = 0; m_pend = 0; m_ptgt = 0;
      return;
    end
    req = m_started && !m_hold;
    m_started = 1;
`ifdef DELAY_SLOT_EN
    if (m_hold) begin
      if (rd && !m_pend) m_pc = tgt;
      if (!st) begin deliver(m_hpc, m_hinstr); m_hold = 0; end
    end else if (req && rdy) begin
      nxt = m_pend ? m_ptgt : (rd ? tgt : m_pc + 32'd1);
      if (!st) deliver(m_pc, instr_of(m_pc));
      else begin m_hold = 1; m_hpc = m_pc; m_hinstr = instr_of(m_pc); end
      m_pc = nxt; m_pend = 0;
    end else begin
      if (req && !st) m_valid = 0;
      if (rd && !m_pend) begin m_pend = 1; m_ptgt = tgt; end
    end
`else
    if (rd) begin
      m_pc = tgt; m_hold = 0; m_valid = 0;
    end else if (m_hold) begin
      if (!st) begin deliver(m_hpc, m_hinstr); m_hold = 0; end
    end else if (req && rdy) begin
      if (!st) deliver(m_pc, instr_of(m_pc));
      else begin m_hold = 1; m_hpc = m_pc; m_hinstr = instr_of(m_pc); end
      m_pc = m_pc + 32'd1;
    end else if (req && !st) begin
      m_valid = 0;
    end
`endif
  endtask

  // Drive one cycle of inputs at the negedge, advance the model, then check at the next negedge.
  task automatic step(input bit r, input bit rdy, input bit st, input bit rd, input logic [31:0] tgt);
    rst_n = r; imem_ready = rdy; stall_i = st; redirect_i = rd; redirect_target = tgt;
    imem_rdata = instr_of(imem_addr);
    model(r, rdy, st, rd, tgt);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; stall_i = 0; redirect_i = 0;
    redirect_target = '0; imem_rdata = '0;

    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h77);
    chk("reset_req",   32'(imem_req),    32'd0);
    chk("reset_valid", 32'(if_id_valid), 32'd0);
    chk("reset_addr",  imem_addr,        32'h100);

    // Streaming from RESET_PC with imem_ready high.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);

    // Memory wait states at pc 5.
    step(1, 1, 0, 1, 32'h5);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Stall while an instruction returns, then release.
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Redirect at pc 0x12, plus a second redirect right after.
    step(1, 1, 0, 1, 32'h12);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 32'h40);
    step(1, 1, 0, 1, 32'h80);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // PC wrap-around at the top of the address space.
    step(1, 0, 0, 1, 32'hFFFF_FFFF);
    step(1, 1, 0, 0, 0);
`ifndef DELAY_SLOT_EN
    chk("wrap_pc",      if_id_pc,      32'hFFFF_FFFF);
    chk("wrap_pc_plus", if_id_pc_plus, 32'h0);
    chk("wrap_addr",    imem_addr,     32'h0);
`endif
    step(1, 1, 0, 0, 0);

    // Reset asserted while in HOLD.
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h33);
    chk("hold_reset_req",   32'(imem_req),    32'd0);
    chk("hold_reset_valid", 32'(if_id_valid), 32'd0);
    chk("hold_reset_pc",    if_id_pc,         32'd0);
    step(1, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 79) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
